btn_sel_ctrl: RTL and testbench
===============================

Name: btn_sel_ctrl

Overview:
- Sequential front end for the board push-buttons (btnU/btnD/btnR/btnL) that drives the 3-bit mux select for the display/datapath mux.
- Synchronizes and debounces each button, detects press edges and arbitrates single versus multiple presses.
- Latches the select until another valid press or an inactivity timeout.
- Replaces direct combinational button decoding, so the select no longer drops to 3'b000 when the button is released.

Parameters:
- DB_LIMIT, 1000000, consecutive cycles a synchronized button must differ from its debounced state before that state flips (10 ms at 100 MHz). Must be >= 1.
- DB_W, 20, width of each debounce counter. Must hold DB_LIMIT.
- TIMEOUT_CYCLES, 500000000, cycles in ACTIVE with no valid press before the select reverts to 3'b000. 0 disables the timeout.
- TO_W, 29, width of the timeout counter. Must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- btnU  in  1  raw up button, asynchronous to clk.
- btnD  in  1  raw down button, asynchronous to clk.
- btnR  in  1  raw right button, asynchronous to clk.
- btnL  in  1  raw left button, asynchronous to clk.
- out2muxSel  out  3  registered mux select.
- sel_valid  out  1  high when out2muxSel holds a button-selected value.
- sel_changed  out  1  one-cycle pulse when out2muxSel changes value.
- btn_conflict  out  1  one-cycle pulse when a multi-button press is rejected.

Behaviour:
- Reset (asynchronous, immediate):
  - out2muxSel=3'b000; sel_valid, sel_changed, btn_conflict = 0.
  - Synchronizers, debounced states, all counters = 0; FSM = IDLE.
- Synchronizer: a 2-FF chain per button, vector order {U,D,R,L}.
- Debounce, per button:
  - When the sync output differs from the debounced state S, the counter increments; when it matches, the counter clears.
  - When the counter reaches DB_LIMIT, S toggles and the counter clears.
  - Press pulse P[i] = S[i] rising edge, one cycle wide.
- Select mapping: L=3'b100, R=3'b101, D=3'b110, U=3'b111.
- Valid press = P one-hot AND S one-hot (no other button held).
- Conflict = P nonzero AND (P not one-hot OR S not one-hot).
- FSM states IDLE, ACTIVE, BLOCKED. All outputs are registered and reflect the decision made in the previous cycle.
  - IDLE, valid press: load the mapped select, sel_valid=1, pulse sel_changed, clear the timeout counter, go ACTIVE.
  - ACTIVE, valid press: load the mapped select and clear the timeout counter. sel_changed pulses only if the value differs; the same button re-pressed gives no pulse but still restarts the timeout.
  - ACTIVE, no press, TIMEOUT_CYCLES != 0: the timeout counter increments each cycle. When it equals TIMEOUT_CYCLES-1: out2muxSel=3'b000, sel_valid=0, pulse sel_changed, go IDLE.
  - IDLE or ACTIVE, conflict: pulse btn_conflict, keep out2muxSel and sel_valid unchanged, freeze the timeout counter, go BLOCKED.
  - BLOCKED: all presses are ignored and cause no further conflict pulses. When S == 0, return to ACTIVE if sel_valid else IDLE; the timeout counter resumes from its frozen value.
- Latency: from a raw button going high (stable) to the out2muxSel update is DB_LIMIT+3 rising edges (2 sync + DB_LIMIT debounce + 1 output register).
- Release: releasing a button never changes out2muxSel.
- Press and timeout in the same cycle: the press wins.
- Simultaneous P bits in one cycle: treated as a conflict.
- Button held through reset deassertion: S starts at 0, so the held button registers as a press after DB_LIMIT+3 edges.
- Reset mid-debounce or mid-timeout: everything clears; no pulse is emitted on reset exit.
- Glitch shorter than DB_LIMIT cycles: the counter clears and there is no effect.

Test Plan (DB_LIMIT=4, TIMEOUT_CYCLES=20):
- rst high, then low with all buttons 0 -> out2muxSel=000, sel_valid=0, no pulses for 50 cycles.
- btnL high for 10 cycles -> out2muxSel=100 and sel_valid=1 on edge 7 after btnL rises, sel_changed one cycle; after release, out2muxSel stays 100 until timeout.
- btnR press, then btnU press, each 10 cycles, buttons released between -> out2muxSel 101 then 111, one sel_changed per change; btnU pressed again -> no sel_changed, timeout restarts.
- btnD held, then btnL pressed while btnD still held -> btn_conflict one pulse, out2muxSel stays 110; further presses ignored until all released; a subsequent btnL press -> 100.
- btnU press, then 20 idle cycles after out2muxSel=111 -> out2muxSel=000, sel_valid=0, sel_changed pulse; btnU toggling with 2-cycle pulses -> no output change.
- btnR press, rst asserted mid-debounce (after 2 of 4 cycles) -> outputs 000 immediately; btnR held across rst deassert -> out2muxSel=101 after 7 edges.

Source files
------------

// File: rtl/btn_sel_ctrl.sv
// Push-button front end for the display/datapath mux select.
// Each raw button is synchronized, debounced and edge-detected. A single clean
// press loads a latched 3-bit select. Multi-button presses are rejected until
// every button is released. An inactivity timeout returns the select to 3'b000.
module btn_sel_ctrl #(
    parameter int unsigned DB_LIMIT       = 1000000,
    parameter int unsigned DB_W           = 20,
    parameter int unsigned TIMEOUT_CYCLES = 500000000,
    parameter int unsigned TO_W           = 29
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnU,
    input  logic       btnD,
    input  logic       btnR,
    input  logic       btnL,
    output logic [2:0] out2muxSel,
    output logic       sel_valid,
    output logic       sel_changed,
    output logic       btn_conflict
);

    // Last debounce count before the state flips: the flip happens on the
    // DB_LIMIT-th consecutive differing cycle.
    localparam logic [DB_W-1:0] DbLast = DB_W'(DB_LIMIT - 1);
    // Timeout fires while the counter holds TIMEOUT_CYCLES-1 and nothing is pressed.
    localparam logic [TO_W-1:0] ToLast =
        (TIMEOUT_CYCLES == 0) ? '0 : TO_W'(TIMEOUT_CYCLES - 1);
    localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StBlocked
    } ctrlState_e;

    // ------------------------------------------------------------------
    // Synchronizer, bit order {U, D, R, L}
    // ------------------------------------------------------------------
    logic [3:0] btnRaw;
    logic [3:0] sync1Q;
    logic [3:0] sync2Q;

    assign btnRaw = {btnU, btnD, btnR, btnL};

    // Two-flop chain per button to tame metastability.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1Q <= '0;
            sync2Q <= '0;
        end else begin
            sync1Q <= btnRaw;
            sync2Q <= sync1Q;
        end
    end

    // ------------------------------------------------------------------
    // Debounce and press-edge detection
    // ------------------------------------------------------------------
    logic [DB_W-1:0] dbCntQ [4];
    logic [DB_W-1:0] dbCntD [4];
    logic [3:0]      dbStateQ;
    logic [3:0]      dbStateD;
    logic [3:0]      dbPrevQ;
    logic [3:0]      pressVec;

    // Count consecutive cycles the synchronized input disagrees with the
    // debounced state; any agreeing cycle restarts the count.
    always_comb begin
        dbStateD = dbStateQ;
        for (int i = 0; i < 4; i++) begin
            dbCntD[i] = '0;
            if (sync2Q[i] != dbStateQ[i]) begin
                if (dbCntQ[i] == DbLast) begin
                    dbStateD[i] = ~dbStateQ[i];
                end else begin
                    dbCntD[i] = dbCntQ[i] + DB_W'(1);
                end
            end
        end
    end

    // Debounce counters, debounced state and its one-cycle-delayed copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                dbCntQ[i] <= '0;
            end
            dbStateQ <= '0;
            dbPrevQ  <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                dbCntQ[i] <= dbCntD[i];
            end
            dbStateQ <= dbStateD;
            dbPrevQ  <= dbStateQ;
        end
    end

    // Rising edge of the debounced state marks a press.
    assign pressVec = dbStateQ & ~dbPrevQ;

    // ------------------------------------------------------------------
    // Press classification
    // ------------------------------------------------------------------
    logic       pressOne;
    logic       heldOne;
    logic       validPress;
    logic       conflictDet;
    logic [2:0] pressSel;

    assign pressOne    = $onehot(pressVec);
    assign heldOne     = $onehot(dbStateQ);
    assign validPress  = pressOne && heldOne;
    assign conflictDet = (pressVec != 4'b0000) && !validPress;

    // Map a single pressed button to its select code.
    always_comb begin
        pressSel = 3'b000;
        unique case (pressVec)
            4'b0001: pressSel = 3'b100;  // L
            4'b0010: pressSel = 3'b101;  // R
            4'b0100: pressSel = 3'b110;  // D
            4'b1000: pressSel = 3'b111;  // U
            default: pressSel = 3'b000;
        endcase
    end

    // ------------------------------------------------------------------
    // Select FSM
    // ------------------------------------------------------------------
    ctrlState_e      stateQ;
    ctrlState_e      stateD;
    logic [2:0]      selQ;
    logic [2:0]      selD;
    logic            validQ;
    logic            validD;
    logic            changedQ;
    logic            changedD;
    logic            conflictQ;
    logic            conflictD;
    logic [TO_W-1:0] toCntQ;
    logic [TO_W-1:0] toCntD;

    // Next-state and registered-output decision. Conflict is checked first so
    // a rejected press never loads the select; a valid press beats timeout.
    always_comb begin
        stateD    = stateQ;
        selD      = selQ;
        validD    = validQ;
        changedD  = 1'b0;
        conflictD = 1'b0;
        toCntD    = toCntQ;
        unique case (stateQ)
            StIdle, StActive: begin
                if (conflictDet) begin
                    // Select, valid and timeout count are all frozen.
                    conflictD = 1'b1;
                    stateD    = StBlocked;
                end else if (validPress) begin
                    selD     = pressSel;
                    validD   = 1'b1;
                    changedD = (pressSel != selQ);
                    toCntD   = '0;
                    stateD   = StActive;
                end else if (stateQ == StActive && TimeoutEn) begin
                    if (toCntQ == ToLast) begin
                        selD     = 3'b000;
                        validD   = 1'b0;
                        changedD = 1'b1;
                        toCntD   = '0;
                        stateD   = StIdle;
                    end else begin
                        toCntD = toCntQ + TO_W'(1);
                    end
                end
            end
            StBlocked: begin
                // Wait for every button to be released before accepting input.
                if (dbStateQ == 4'b0000) begin
                    stateD = validQ ? StActive : StIdle;
                end
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    // State, select, flags and timeout counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ    <= StIdle;
            selQ      <= 3'b000;
            validQ    <= 1'b0;
            changedQ  <= 1'b0;
            conflictQ <= 1'b0;
            toCntQ    <= '0;
        end else begin
            stateQ    <= stateD;
            selQ      <= selD;
            validQ    <= validD;
            changedQ  <= changedD;
            conflictQ <= conflictD;
            toCntQ    <= toCntD;
        end
    end

    assign out2muxSel   = selQ;
    assign sel_valid    = validQ;
    assign sel_changed  = changedQ;
    assign btn_conflict = conflictQ;

endmodule

// File: tb/tb_btn_sel_ctrl.sv
// Bench for btn_sel_ctrl with a short debounce and timeout. Directed scenarios
// plus random button traffic, each cycle compared against a behavioural model.
module tb_btn_sel_ctrl;

    localparam int DBL = 4;
    localparam int TMO = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btnVec = 4'b0000;  // {U, D, R, L}
    logic [2:0] out2muxSel;
    logic       sel_valid;
    logic       sel_changed;
    logic       btn_conflict;

    int checkCount = 0;
    int failCount  = 0;
    int chgCount   = 0;
    int confCount  = 0;

    // Behavioural model state
    logic [3:0] mSync1, mSync2, mS, mSPrev;
    int         mRun [4];
    int         mMode;   // 0 idle, 1 active, 2 blocked
    int         mTo;     // idle cycles spent in active mode
    logic [2:0] mSel;
    logic       mValid, mChg, mConf;

    btn_sel_ctrl #(
        .DB_LIMIT      (DBL),
        .DB_W          (3),
        .TIMEOUT_CYCLES(TMO),
        .TO_W          (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btnU        (btnVec[3]),
        .btnD        (btnVec[2]),
        .btnR        (btnVec[1]),
        .btnL        (btnVec[0]),
        .out2muxSel  (out2muxSel),
        .sel_valid   (sel_valid),
        .sel_changed (sel_changed),
        .btn_conflict(btn_conflict)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input int got, input int exp);
        checkCount++;
        if (got != exp) begin
            failCount++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mSync1 = '0; mSync2 = '0; mS = '0; mSPrev = '0;
        for (int i = 0; i < 4; i++) mRun[i] = 0;
        mMode = 0; mTo = 0; mSel = '0; mValid = 0; mChg = 0; mConf = 0;
    endtask

    // One rising edge of model time, using the values held before the edge.
    task automatic modelStep(input logic [3:0] raw);
        logic [3:0] p;
        logic [3:0] newS;
        int np, ns, idx;
        p  = mS & ~mSPrev;
        np = $countones(p);
        ns = $countones(mS);
        mChg = 0; mConf = 0;
        if (mMode == 2) begin
            if (mS == 4'b0000) mMode = mValid ? 1 : 0;
        end else if (np != 0 && (np != 1 || ns != 1)) begin
            mConf = 1;
            mMode = 2;
        end else if (np == 1) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (p[i]) idx = i;
            mChg   = (mSel != 3'(4 + idx));
            mSel   = 3'(4 + idx);
            mValid = 1;
            mTo    = 0;
            mMode  = 1;
        end else if (mMode == 1) begin
            mTo++;
            if (mTo == TMO) begin
                mSel = 0; mValid = 0; mChg = 1; mMode = 0; mTo = 0;
            end
        end
        newS = mS;
        for (int i = 0; i < 4; i++) begin
            if (mSync2[i] != mS[i]) begin
                mRun[i]++;
                if (mRun[i] == DBL) begin
                    newS[i] = ~mS[i];
                    mRun[i] = 0;
                end
            end else begin
                mRun[i] = 0;
            end
        end
        mSPrev = mS;
        mS     = newS;
        mSync2 = mSync1;
        mSync1 = raw;
    endtask

    task automatic stepCycle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            if (rst) modelReset();
            else modelStep(btnVec);
            #1;
            checkVal("sel", int'(out2muxSel), int'(mSel));
            checkVal("valid", int'(sel_valid), int'(mValid));
            checkVal("changed", int'(sel_changed), int'(mChg));
            checkVal("conflict", int'(btn_conflict), int'(mConf));
            chgCount  += int'(sel_changed);
            confCount += int'(btn_conflict);
        end
    endtask

    task automatic doReset(input int holdCycles);
        rst = 1'b1;
        #1;
        modelReset();
        checkVal("rst_sel", int'(out2muxSel), 0);
        checkVal("rst_valid", int'(sel_valid), 0);
        checkVal("rst_changed", int'(sel_changed), 0);
        checkVal("rst_conflict", int'(btn_conflict), 0);
        stepCycle(holdCycles);
        rst = 1'b0;
    endtask

    int chgBase, confBase, hold, r;

    initial begin
        modelReset();
        doReset(3);

        // Quiet after reset
        stepCycle(50);
        checkVal("quiet_changed_cnt", chgCount, 0);
        checkVal("quiet_conflict_cnt", confCount, 0);

        // Left press: latency and hold after release
        btnVec = 4'b0001;
        stepCycle(6);
        checkVal("lat_early_sel", int'(out2muxSel), 0);
        stepCycle(1);
        checkVal("lat_sel_L", int'(out2muxSel), 3'b100);
        checkVal("lat_valid_L", int'(sel_valid), 1);
        checkVal("lat_changed_L", int'(sel_changed), 1);
        stepCycle(3);
        btnVec = 4'b0000;
        stepCycle(10);
        checkVal("release_keeps_L", int'(out2muxSel), 3'b100);
        stepCycle(10);
        checkVal("timeout_after_L", int'(out2muxSel), 0);

        // R then U, then U again restarts the timeout without a pulse
        chgBase = chgCount;
        btnVec = 4'b0010; stepCycle(10);
        btnVec = 4'b0000; stepCycle(8);
        checkVal("sel_R", int'(out2muxSel), 3'b101);
        btnVec = 4'b1000; stepCycle(8);
        checkVal("sel_U", int'(out2muxSel), 3'b111);
        checkVal("chg_cnt_RU", chgCount - chgBase, 2);
        btnVec = 4'b0000; stepCycle(8);
        chgBase = chgCount;
        btnVec = 4'b1000; stepCycle(8);
        btnVec = 4'b0000; stepCycle(6);
        checkVal("repress_restart_sel", int'(out2muxSel), 3'b111);
        checkVal("repress_no_chg", chgCount - chgBase, 0);
        stepCycle(20);
        checkVal("timeout_after_U", int'(out2muxSel), 0);

        // D held, then L: one conflict, presses ignored while blocked
        confBase = confCount;
        btnVec = 4'b0100; stepCycle(10);
        checkVal("sel_D", int'(out2muxSel), 3'b110);
        btnVec = 4'b0101; stepCycle(10);
        checkVal("conflict_once", confCount - confBase, 1);
        checkVal("conflict_keeps_D", int'(out2muxSel), 3'b110);
        btnVec = 4'b0100; stepCycle(8);
        btnVec = 4'b0101; stepCycle(10);
        checkVal("blocked_no_conflict", confCount - confBase, 1);
        checkVal("blocked_keeps_D", int'(out2muxSel), 3'b110);
        btnVec = 4'b0000; stepCycle(10);
        btnVec = 4'b0001; stepCycle(10);
        checkVal("unblocked_L", int'(out2muxSel), 3'b100);
        btnVec = 4'b0000; stepCycle(30);

        // U press, then exact timeout boundary, then short glitches
        btnVec = 4'b1000; stepCycle(7);
        checkVal("sel_U2", int'(out2muxSel), 3'b111);
        stepCycle(3);
        btnVec = 4'b0000; stepCycle(16);
        checkVal("to_edge_before", int'(out2muxSel), 3'b111);
        stepCycle(1);
        checkVal("to_edge_sel", int'(out2muxSel), 0);
        checkVal("to_edge_valid", int'(sel_valid), 0);
        checkVal("to_edge_changed", int'(sel_changed), 1);
        chgBase = chgCount;
        for (int g = 0; g < 5; g++) begin
            btnVec = 4'b1000; stepCycle(2);
            btnVec = 4'b0000; stepCycle(2);
        end
        stepCycle(10);
        checkVal("glitch_sel", int'(out2muxSel), 0);
        checkVal("glitch_no_chg", chgCount - chgBase, 0);

        // Reset mid-debounce, button held across reset release
        btnVec = 4'b0001; stepCycle(10);
        checkVal("pre_rst_L", int'(out2muxSel), 3'b100);
        btnVec = 4'b0010; stepCycle(4);
        doReset(3);
        stepCycle(6);
        checkVal("held_rst_early", int'(out2muxSel), 0);
        stepCycle(1);
        checkVal("held_rst_R", int'(out2muxSel), 3'b101);
        btnVec = 4'b0000; stepCycle(10);

        // Random traffic against the model
        for (int s = 0; s < 300; s++) begin
            r = $urandom_range(0, 9);
            if (r <= 3) btnVec = 4'b0000;
            else if (r <= 7) btnVec = 4'(1 << $urandom_range(0, 3));
            else if (r == 8) btnVec = 4'($urandom_range(0, 15));
            else btnVec = btnVec | 4'(1 << $urandom_range(0, 3));
            hold = $urandom_range(1, 14);
            if ($urandom_range(0, 59) == 0) doReset(2);
            stepCycle(hold);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
